// File: rtl/veririsc_sequencer.sv
// -----------------------------------------------------------------------------
// veririsc_sequencer
//   Instruction-phase controller for the VeriRISC CPU. An internal 3-bit phase
//   counter walks eight phases per instruction. The load/enable strobes for the
//   PC, accumulator, IR and memory are decoded combinationally from the
//   registered phase, the IR opcode and the accumulator zero flag.
//
//   Optional feature (macro SEQ_SINGLE_STEP_EN):
//     When defined, an extra input 'step' is present. The sequencer parks in
//     phase 0 until a cycle with step=1, then runs phases 1..7 freely.
//     When undefined, there is no step port and phase 0 lasts one cycle.
//
// Parameters
//   WIDTH     opcode width (the opcode encoding assumes 3)
//   CYC_W     width of the retired-instruction counter
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   step       in   single-step advance (only with SEQ_SINGLE_STEP_EN)
//   opcode     in   IR opcode, used in phases 4..7
//   zero       in   accumulator == 0
//   sel        out  address mux select: 1 = PC, 0 = IR operand
//   rd         out  memory read enable
//   ld_ir      out  IR load
//   inc_pc     out  PC increment
//   halt       out  HLT decoded (phase 4), held high while halted
//   ld_pc      out  PC load (jump)
//   data_e     out  AC -> data bus drive enable
//   ld_ac      out  AC load
//   wr         out  memory write strobe
//   halted     out  sticky halt status, cleared only by rst
//   phase      out  current phase (debug/trace)
//   instr_cnt  out  retired instructions, saturating
// -----------------------------------------------------------------------------
module veririsc_sequencer #(
  parameter int WIDTH = 3,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [WIDTH-1:0] opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             halt,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic             halted,
  output logic [2:0]       phase,
  output logic [CYC_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [WIDTH-1:0] OP_HLT = WIDTH'(0);
  localparam logic [WIDTH-1:0] OP_SKZ = WIDTH'(1);
  localparam logic [WIDTH-1:0] OP_ADD = WIDTH'(2);
  localparam logic [WIDTH-1:0] OP_AND = WIDTH'(3);
  localparam logic [WIDTH-1:0] OP_XOR = WIDTH'(4);
  localparam logic [WIDTH-1:0] OP_LDA = WIDTH'(5);
  localparam logic [WIDTH-1:0] OP_STO = WIDTH'(6);
  localparam logic [WIDTH-1:0] OP_JMP = WIDTH'(7);

  localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};

  phase_t           phase_q;
  phase_t           phase_d;
  logic [2:0]       phase_inc;
  logic             halted_q;
  logic             halted_d;
  logic [CYC_W-1:0] cnt_q;
  logic [CYC_W-1:0] cnt_d;
  logic             advance;

  logic is_hlt;
  logic is_skz;
  logic is_alu;
  logic is_sto;
  logic is_jmp;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  assign phase_inc = phase_q + 3'd1;

  // Next-state logic. A HLT in phase 4 sets the sticky flag instead of
  // advancing, so the phase freezes at 4. The retired-instruction count only
  // moves on a real 7->0 wrap, which can never happen while halted.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    advance  = 1'b0;
    if (!halted_q) begin
      if ((phase_q == OP_ADDR) && is_hlt) begin
        halted_d = 1'b1;
      end else begin
        advance = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        if ((phase_q == INST_ADDR) && !step) begin
          advance = 1'b0;
        end
`endif
      end
    end
    if (advance) begin
      phase_d = phase_t'(phase_inc);
      if ((phase_q == STORE) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Strobe decode from the registered phase. Reset overrides everything;
  // once halted only the halt indication stays high.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (rst) begin
      sel = 1'b0;
    end else if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          rd = is_alu;
        end
        ALU_OP: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign halted    = halted_q;
  assign phase     = phase_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_veririsc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_veririsc_sequencer
//   Directed scoreboard bench for veririsc_sequencer. The driver pushes the
//   hand-computed expected outputs for each cycle into a queue; a monitor on
//   the falling edge pops and compares. The counter width is reduced so that
//   saturation is reachable in a few hundred cycles.
//   Strobe vector order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
// -----------------------------------------------------------------------------
module tb_veririsc_sequencer;

  localparam int CW = 4;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [8:0] F0 = 9'b100000000;
  localparam logic [8:0] F1 = 9'b110000000;
  localparam logic [8:0] F2 = 9'b111000000;
  localparam logic [8:0] F3 = 9'b111000000;
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] S_INC = 9'b000100000;
  localparam logic [8:0] S_HALT = 9'b000010000;

  logic          clk;
  logic          rst;
  logic          step;
  logic [2:0]    opcode;
  logic          zero;
  logic          sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, halted;
  logic [2:0]    phase;
  logic [CW-1:0] instr_cnt;

  typedef struct {
    string         name;
    logic [2:0]    ph;
    logic [8:0]    sb;
    logic          hd;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  logic [CW-1:0] exp_cnt;

  logic [7:0][8:0] t_add;
  logic [7:0][8:0] t_skz1;
  logic [7:0][8:0] t_skz0;
  logic [7:0][8:0] t_sto;
  logic [7:0][8:0] t_jmp;

  veririsc_sequencer #(.WIDTH(3), .CYC_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .opcode    (opcode),
    .zero      (zero),
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .halt      (halt),
    .ld_pc     (ld_pc),
    .data_e    (data_e),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .halted    (halted),
    .phase     (phase),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e);
    logic [8:0] act;
    act = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    checks++;
    if (act !== e.sb || phase !== e.ph || halted !== e.hd || instr_cnt !== e.cnt) begin
      failures++;
      $display("[TB] FAIL %s: got phase=%0d strobes=%b halted=%b cnt=%0d, expected phase=%0d strobes=%b halted=%b cnt=%0d",
               e.name, phase, act, halted, instr_cnt, e.ph, e.sb, e.hd, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  task automatic applyStimulus(input string nm, input logic [2:0] op, input logic z,
                               input logic r, input logic st, input logic [2:0] ph,
                               input logic [8:0] sb, input logic hd, input logic [CW-1:0] c);
    exp_t e;
    opcode = op;
    zero   = z;
    rst    = r;
    step   = st;
    e.name = nm;
    e.ph   = ph;
    e.sb   = sb;
    e.hd   = hd;
    e.cnt  = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input string nm, input logic [2:0] op, input logic z,
                          input logic [7:0][8:0] tbl);
    for (int p = 0; p < 8; p++) begin
      applyStimulus($sformatf("%s_p%0d", nm, p), op, z, 1'b0, 1'b1, 3'(p), tbl[p], 1'b0, exp_cnt);
    end
    if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = '0;
    t_add  = {9'b010000010, 9'b010000000, 9'b010000000, S_INC, F3, F2, F1, F0};
    t_skz1 = {NONE, S_INC, NONE, S_INC, F3, F2, F1, F0};
    t_skz0 = {NONE, NONE, NONE, S_INC, F3, F2, F1, F0};
    t_sto  = {9'b000000101, 9'b000000100, NONE, S_INC, F3, F2, F1, F0};
    t_jmp  = {9'b000001000, 9'b000001000, NONE, S_INC, F3, F2, F1, F0};

    rst    = 1'b1;
    step   = 1'b1;
    opcode = ADD;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("reset_c1", ADD, 1'b0, 1'b1, 1'b1, 3'd0, NONE, 1'b0, '0);
    applyStimulus("reset_c2", ADD, 1'b0, 1'b1, 1'b1, 3'd0, NONE, 1'b0, '0);

    runInstr("add", ADD, 1'b0, t_add);
    runInstr("skz_z1", SKZ, 1'b1, t_skz1);
    runInstr("skz_z0", SKZ, 1'b0, t_skz0);
    runInstr("sto", STO, 1'b0, t_sto);
    runInstr("jmp", JMP, 1'b0, t_jmp);

    // Push the counter to saturation and beyond.
    for (int i = 0; i < 12; i++) begin
      runInstr($sformatf("sat%0d", i), ADD, 1'b0, t_add);
    end

    // Reset in the middle of a JMP, in phase 5.
    for (int p = 0; p < 5; p++) begin
      applyStimulus($sformatf("jmp_rst_p%0d", p), JMP, 1'b0, 1'b0, 1'b1, 3'(p), t_jmp[p], 1'b0, exp_cnt);
    end
    applyStimulus("jmp_rst_p5", JMP, 1'b0, 1'b1, 1'b1, 3'd5, NONE, 1'b0, exp_cnt);
    exp_cnt = '0;
    runInstr("after_rst", JMP, 1'b0, t_jmp);

    // Halt: freeze at phase 4 for 20 cycles, then clear by reset.
    for (int p = 0; p < 4; p++) begin
      applyStimulus($sformatf("hlt_p%0d", p), HLT, 1'b0, 1'b0, 1'b1, 3'(p), t_add[p], 1'b0, exp_cnt);
    end
    applyStimulus("hlt_p4", HLT, 1'b0, 1'b0, 1'b1, 3'd4, 9'b000110000, 1'b0, exp_cnt);
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("halted%0d", i), (i < 10) ? HLT : ADD, 1'b1, 1'b0, 1'b1,
                    3'd4, S_HALT, 1'b1, exp_cnt);
    end
    applyStimulus("halted_rst", ADD, 1'b0, 1'b1, 1'b1, 3'd4, NONE, 1'b1, exp_cnt);
    exp_cnt = '0;
    runInstr("post_halt", ADD, 1'b0, t_add);

`ifdef SEQ_SINGLE_STEP_EN
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("step_hold%0d", i), ADD, 1'b0, 1'b0, 1'b0, 3'd0, F0, 1'b0, exp_cnt);
    end
    applyStimulus("step_pulse", ADD, 1'b0, 1'b0, 1'b1, 3'd0, F0, 1'b0, exp_cnt);
    for (int p = 1; p < 8; p++) begin
      applyStimulus($sformatf("step_run_p%0d", p), ADD, 1'b0, 1'b0, 1'b0, 3'(p), t_add[p], 1'b0, exp_cnt);
    end
    exp_cnt = exp_cnt + 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("step_park%0d", i), ADD, 1'b0, 1'b0, 1'b0, 3'd0, F0, 1'b0, exp_cnt);
    end
`endif

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
